// File: rtl/main_memory_responder_if.sv
// Core memory bus and program-loader handshake for main_memory_responder.
// master: core/loader side (drives address, data, strobes); slave: memory.
//   mem_addr/mem_wdata/mem_we -> memory, mem_rdata <- memory (same cycle)
//   load_en/ld_valid/ld_index/ld_data -> memory, ld_ready/loading <- memory
interface main_memory_responder_if #(
    parameter int IDX_W = 10
);
    logic [31:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic [31:0]  mem_wdata;
    logic         mem_we;
    logic         load_en;
    logic         ld_valid;
    logic         ld_ready;
    logic [IDX_W:0] ld_index;
    logic [31:0]  ld_data;
    logic         loading;

    modport master (
        output mem_addr, mem_wdata, mem_we,
        output load_en, ld_valid, ld_index, ld_data,
        input  mem_rdata, ld_ready, loading
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we,
        input  load_en, ld_valid, ld_index, ld_data,
        output mem_rdata, ld_ready, loading
    );
endinterface

// File: rtl/main_memory_responder.sv
// Unified instruction/data RAM for the multicycle RV32I core, with a
// side loader for program images, sticky error flags and debug counters.
// Ports: clk, rst (sync, active-high); bus (slave modport: core bus +
//   loader handshake); err_clr in; err_oob, err_misaligned, err_addr,
//   wr_count, ld_count out.
module main_memory_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    main_memory_responder_if.slave bus,
    input  logic        err_clr,
    output logic        err_oob,
    output logic        err_misaligned,
    output logic [31:0] err_addr,
    output logic [15:0] wr_count,
    output logic [15:0] ld_count
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    // Byte span of the RAM; 33 bits so 4*DEPTH cannot wrap.
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    logic [0:0]  state;
    logic [31:0] ram [DEPTH_WORDS];

    logic [31:0]      off;
    logic             in_range;
    logic             aligned;
    logic [IDX_W-1:0] idx;
    logic             run;

    assign off      = bus.mem_addr - BASE_ADDR;
    assign in_range = (bus.mem_addr >= BASE_ADDR)
                   && ({1'b0, off} < SPAN);
    assign aligned  = (bus.mem_addr[1:0] == 2'b00);
    assign idx      = off[IDX_W+1:2];
    assign run      = (state == ST_RUN);

    // ld_ready/loading come straight from the state flop.
    assign bus.ld_ready = ~run;
    assign bus.loading  = ~run;

    // Zero-latency read: the core samples data in the address cycle.
    assign bus.mem_rdata = (run && in_range) ? ram[idx] : 32'h0;

    logic core_go;
    logic core_wr;
    logic core_oob;
    logic core_mis;
    logic ld_fire;
    logic ld_ok;
    logic ld_oob;

    assign core_go  = !rst && run && bus.mem_we;
    assign core_wr  = core_go && in_range && aligned;
    assign core_oob = core_go && !in_range;
    assign core_mis = core_go && in_range && !aligned;

    // Index MSB set means ld_index >= DEPTH_WORDS (power of two).
    assign ld_fire = !rst && !run && bus.ld_valid;
    assign ld_ok   = ld_fire && !bus.ld_index[IDX_W];
    assign ld_oob  = ld_fire && bus.ld_index[IDX_W];

    logic        new_err;
    logic        had_err;
    logic [31:0] new_addr;

    assign new_err  = core_oob || core_mis || ld_oob;
    // A clear in the same cycle makes the new error the "first" one.
    assign had_err  = (err_oob || err_misaligned) && !err_clr;
    assign new_addr = ld_oob
                    ? BASE_ADDR + (32'(bus.ld_index) << 2)
                    : bus.mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= bus.load_en ? ST_LOAD : ST_RUN;
        end
    end

    // RAM has no reset so a loaded image survives rst.
    always_ff @(posedge clk) begin
        unique case (1'b1)
            core_wr: ram[idx] <= bus.mem_wdata;
            ld_ok:   ram[bus.ld_index[IDX_W-1:0]] <= bus.ld_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob        <= 1'b0;
            err_misaligned <= 1'b0;
            err_addr       <= 32'h0;
        end else begin
            if (err_clr) begin
                err_oob        <= 1'b0;
                err_misaligned <= 1'b0;
                err_addr       <= 32'h0;
            end
            if (core_oob || ld_oob) begin
                err_oob <= 1'b1;
            end
            if (core_mis) begin
                err_misaligned <= 1'b1;
            end
            if (new_err && !had_err) begin
                err_addr <= new_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= 16'h0;
            ld_count <= 16'h0;
        end else begin
            if (core_wr && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (ld_ok && ld_count != 16'hFFFF) begin
                ld_count <= ld_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed scenarios
// followed by randomized traffic checked against a behavioural model.
module tb_main_memory_responder;
    localparam int          DEPTH = 1024;
    localparam int          IDX_W = 10;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_clr = 1'b0;
    logic        err_oob;
    logic        err_misaligned;
    logic [31:0] err_addr;
    logic [15:0] wr_count;
    logic [15:0] ld_count;

    main_memory_responder_if #(.IDX_W(IDX_W)) bus ();

    main_memory_responder #(
        .BASE_ADDR(BASE),
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_clr(err_clr),
        .err_oob(err_oob),
        .err_misaligned(err_misaligned),
        .err_addr(err_addr),
        .wr_count(wr_count),
        .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] prog [4] = '{32'h00500093, 32'h00100113,
                              32'h002081B3, 32'h0000006F};

    // Behavioural model: memory as an array, plus flags and counts.
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_load = 0;
    bit          m_oob = 0;
    bit          m_mis = 0;
    logic [31:0] m_eaddr = 32'h0;
    int          m_wr = 0;
    int          m_ld = 0;

    function automatic bit in_rng(logic [31:0] a);
        return a >= BASE && (a - BASE) < 32'(4 * DEPTH);
    endfunction

    function automatic int word_of(logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic bit rd_known();
        if (m_load || !in_rng(bus.mem_addr)) return 1'b1;
        return m_known[word_of(bus.mem_addr)];
    endfunction

    function automatic logic [31:0] exp_rd();
        if (m_load || !in_rng(bus.mem_addr)) return 32'h0;
        return m_mem[word_of(bus.mem_addr)];
    endfunction

    // Advance the model by one edge using the current inputs, then clock.
    task automatic cycle();
        bit          was_err;
        bit          n_oob;
        bit          n_mis;
        logic [31:0] ea;
        int          w;
        was_err = (m_oob || m_mis) && !err_clr;
        n_oob = 0;
        n_mis = 0;
        ea = 32'h0;
        if (rst) begin
            m_load = 0; m_oob = 0; m_mis = 0;
            m_eaddr = 32'h0; m_wr = 0; m_ld = 0;
        end else begin
            if (!m_load && bus.mem_we) begin
                if (!in_rng(bus.mem_addr)) begin
                    n_oob = 1; ea = bus.mem_addr;
                end else if (bus.mem_addr % 4 != 0) begin
                    n_mis = 1; ea = bus.mem_addr;
                end else begin
                    w = word_of(bus.mem_addr);
                    m_mem[w] = bus.mem_wdata;
                    m_known[w] = 1;
                    if (m_wr < 65535) m_wr++;
                end
            end
            if (m_load && bus.ld_valid) begin
                if (int'(bus.ld_index) < DEPTH) begin
                    m_mem[int'(bus.ld_index)] = bus.ld_data;
                    m_known[int'(bus.ld_index)] = 1;
                    if (m_ld < 65535) m_ld++;
                end else begin
                    n_oob = 1;
                    ea = BASE + 32'(bus.ld_index) * 4;
                end
            end
            if (err_clr) begin
                m_oob = 0; m_mis = 0; m_eaddr = 32'h0;
            end
            if (n_oob) m_oob = 1;
            if (n_mis) m_mis = 1;
            if ((n_oob || n_mis) && !was_err) m_eaddr = ea;
            m_load = bus.load_en;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_we = 0;
        bus.ld_valid = 0;
        err_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        bus.load_en = 0;
        idle();
        cycle();
        cycle();
        rst = 0;
        total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL rst_loading got=%b want=0", bus.loading); end
        total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ld_ready got=%b want=0", bus.ld_ready); end
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL rst_err_oob got=%b want=0", err_oob); end
        total++; if (err_misaligned !== 1'b0) begin bad++; $display("FAIL rst_err_mis got=%b want=0", err_misaligned); end
        total++; if (err_addr !== 32'h0) begin bad++; $display("FAIL rst_err_addr got=%h want=0", err_addr); end
        total++; if (wr_count !== 16'h0) begin bad++; $display("FAIL rst_wr_count got=%0d want=0", wr_count); end
        total++; if (ld_count !== 16'h0) begin bad++; $display("FAIL rst_ld_count got=%0d want=0", ld_count); end
    endtask

    task automatic test_loader_fill();
        bus.load_en = 1;
        cycle();
        total++; if (bus.loading !== 1'b1) begin bad++; $display("FAIL fill_loading got=%b want=1", bus.loading); end
        total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL fill_ld_ready got=%b want=1", bus.ld_ready); end
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1;
            bus.ld_index = 11'(i);
            bus.ld_data = prog[i];
            // last beat lands on the edge where load_en drops
            if (i == 3) bus.load_en = 0;
            cycle();
        end
        bus.ld_valid = 0;
        total++; if (ld_count !== 16'd4) begin bad++; $display("FAIL fill_ld_count got=%0d want=4", ld_count); end
        total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL fill_loading_off got=%b want=0", bus.loading); end
        for (int i = 0; i < 4; i++) begin
            bus.mem_addr = BASE + 32'(4 * i);
            #1;
            total++; if (bus.mem_rdata !== prog[i]) begin bad++; $display("FAIL fill_word%0d got=%h want=%h", i, bus.mem_rdata, prog[i]); end
        end
    endtask

    task automatic test_core_store();
        bus.mem_addr = 32'h8000_0010;
        bus.mem_wdata = 32'hDEADBEEF;
        bus.mem_we = 1;
        cycle();
        bus.mem_we = 0;
        #1;
        total++; if (bus.mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_rd got=%h want=deadbeef", bus.mem_rdata); end
        total++; if (wr_count !== 16'd1) begin bad++; $display("FAIL store_wr_count got=%0d want=1", wr_count); end
        bus.mem_wdata = 32'hCAFEF00D;
        bus.mem_we = 1;
        #1;
        total++; if (bus.mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_rdw_old got=%h want=deadbeef", bus.mem_rdata); end
        cycle();
        bus.mem_we = 0;
        #1;
        total++; if (bus.mem_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL store_rdw_new got=%h want=cafef00d", bus.mem_rdata); end
        bus.mem_addr = 32'h8000_0FFC;
        bus.mem_wdata = 32'h0A5A5A5A;
        bus.mem_we = 1;
        cycle();
        bus.mem_we = 0;
        #1;
        total++; if (bus.mem_rdata !== 32'h0A5A5A5A) begin bad++; $display("FAIL store_last got=%h want=0a5a5a5a", bus.mem_rdata); end
        total++; if (wr_count !== 16'd3) begin bad++; $display("FAIL store_wr_count3 got=%0d want=3", wr_count); end
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL store_last_oob got=%b want=0", err_oob); end
    endtask

    task automatic test_oob();
        bus.mem_addr = 32'h8000_1000;
        bus.mem_wdata = 32'h11111111;
        bus.mem_we = 1;
        #1;
        total++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL oob_rd got=%h want=0", bus.mem_rdata); end
        cycle();
        bus.mem_we = 0;
        total++; if (err_oob !== 1'b1) begin bad++; $display("FAIL oob_flag got=%b want=1", err_oob); end
        total++; if (err_addr !== 32'h8000_1000) begin bad++; $display("FAIL oob_addr got=%h want=80001000", err_addr); end
        total++; if (wr_count !== 16'd3) begin bad++; $display("FAIL oob_wr_count got=%0d want=3", wr_count); end
        bus.mem_addr = 32'h8000_0FFC;
        #1;
        total++; if (bus.mem_rdata !== 32'h0A5A5A5A) begin bad++; $display("FAIL oob_nochange got=%h want=0a5a5a5a", bus.mem_rdata); end
        bus.mem_addr = 32'h7FFF_FFFC;
        bus.mem_we = 1;
        #1;
        total++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL oob_low_rd got=%h want=0", bus.mem_rdata); end
        cycle();
        bus.mem_we = 0;
        total++; if (err_addr !== 32'h8000_1000) begin bad++; $display("FAIL oob_addr_keep got=%h want=80001000", err_addr); end
    endtask

    task automatic test_misaligned();
        err_clr = 1;
        cycle();
        err_clr = 0;
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL clr_oob got=%b want=0", err_oob); end
        total++; if (err_addr !== 32'h0) begin bad++; $display("FAIL clr_addr got=%h want=0", err_addr); end
        bus.mem_addr = 32'h8000_0002;
        bus.mem_wdata = 32'hFFFFFFFF;
        bus.mem_we = 1;
        cycle();
        bus.mem_we = 0;
        total++; if (err_misaligned !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b want=1", err_misaligned); end
        total++; if (err_addr !== 32'h8000_0002) begin bad++; $display("FAIL mis_addr got=%h want=80000002", err_addr); end
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL mis_oob got=%b want=0", err_oob); end
        #1;
        total++; if (bus.mem_rdata !== 32'h00500093) begin bad++; $display("FAIL mis_word0 got=%h want=00500093", bus.mem_rdata); end
        err_clr = 1;
        cycle();
        err_clr = 0;
        total++; if (err_misaligned !== 1'b0) begin bad++; $display("FAIL mis_clr got=%b want=0", err_misaligned); end
        err_clr = 1;
        bus.mem_addr = 32'h8000_0001;
        bus.mem_we = 1;
        cycle();
        total++; if (err_misaligned !== 1'b1) begin bad++; $display("FAIL mis_clr_race got=%b want=1", err_misaligned); end
        total++; if (err_addr !== 32'h8000_0001) begin bad++; $display("FAIL mis_clr_race_addr got=%h want=80000001", err_addr); end
        bus.mem_addr = 32'h8000_0003;
        cycle();
        idle();
        total++; if (err_addr !== 32'h8000_0003) begin bad++; $display("FAIL mis_clr_recapture got=%h want=80000003", err_addr); end
        err_clr = 1;
        cycle();
        err_clr = 0;
    endtask

    task automatic test_mode_isolation();
        bus.load_en = 1;
        cycle();
        bus.mem_addr = 32'h8000_0000;
        bus.mem_wdata = 32'hFFFFFFFF;
        bus.mem_we = 1;
        #1;
        total++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL iso_rd got=%h want=0", bus.mem_rdata); end
        cycle();
        bus.mem_we = 0;
        total++; if (wr_count !== 16'd3) begin bad++; $display("FAIL iso_wr_count got=%0d want=3", wr_count); end
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL iso_no_flag got=%b want=0", err_oob); end
        bus.ld_valid = 1;
        bus.ld_index = 11'd1024;
        bus.ld_data = 32'h77777777;
        cycle();
        bus.ld_valid = 0;
        total++; if (err_oob !== 1'b1) begin bad++; $display("FAIL iso_ld_oob got=%b want=1", err_oob); end
        total++; if (err_addr !== 32'h8000_1000) begin bad++; $display("FAIL iso_ld_addr got=%h want=80001000", err_addr); end
        total++; if (ld_count !== 16'd4) begin bad++; $display("FAIL iso_ld_count got=%0d want=4", ld_count); end
        bus.load_en = 0;
        cycle();
        #1;
        total++; if (bus.mem_rdata !== 32'h00500093) begin bad++; $display("FAIL iso_word0 got=%h want=00500093", bus.mem_rdata); end
        err_clr = 1;
        cycle();
        err_clr = 0;
    endtask

    task automatic test_reset_retention();
        bus.mem_addr = 32'h8000_0004;
        bus.mem_wdata = 32'h12345678;
        bus.mem_we = 1;
        cycle();
        bus.mem_we = 0;
        bus.load_en = 1;
        cycle();
        bus.ld_valid = 1;
        bus.ld_index = 11'd5;
        bus.ld_data = 32'h55555555;
        cycle();
        bus.ld_valid = 0;
        total++; if (ld_count !== 16'd5) begin bad++; $display("FAIL ret_ld_count got=%0d want=5", ld_count); end
        rst = 1;
        bus.mem_we = 1;
        cycle();
        rst = 0;
        bus.mem_we = 0;
        bus.load_en = 0;
        total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL ret_loading got=%b want=0", bus.loading); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL ret_wr_count got=%0d want=0", wr_count); end
        total++; if (ld_count !== 16'd0) begin bad++; $display("FAIL ret_ld_count0 got=%0d want=0", ld_count); end
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL ret_err got=%b want=0", err_oob); end
        #1;
        total++; if (bus.mem_rdata !== 32'h12345678) begin bad++; $display("FAIL ret_word1 got=%h want=12345678", bus.mem_rdata); end
        bus.mem_addr = 32'h8000_0014;
        #1;
        total++; if (bus.mem_rdata !== 32'h55555555) begin bad++; $display("FAIL ret_word5 got=%h want=55555555", bus.mem_rdata); end
    endtask

    task automatic test_random();
        int sel;
        logic [31:0] a;
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 7));
            a = BASE + (32'($urandom_range(0, 4095)) & ~32'h3);
            if (sel == 4) a = a | 32'($urandom_range(0, 3));
            if (sel == 5) a = ($urandom % 2) ? 32'h8000_0FFC : 32'h8000_1000;
            if (sel == 6) a = 32'h7FFF_FFFC + 32'($urandom_range(0, 7));
            if (sel == 7) a = $urandom;
            bus.mem_addr = a;
            bus.mem_wdata = $urandom;
            bus.mem_we = ($urandom % 2) == 0;
            if ($urandom_range(0, 7) == 0) bus.load_en = ~bus.load_en;
            bus.ld_valid = ($urandom % 2) == 0;
            bus.ld_index = 11'($urandom_range(0, 1100));
            bus.ld_data = $urandom;
            err_clr = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 99) == 0;
            #1;
            if (rd_known()) begin
                total++; if (bus.mem_rdata !== exp_rd()) begin bad++; $display("FAIL rnd_rd i=%0d addr=%h got=%h want=%h", i, a, bus.mem_rdata, exp_rd()); end
            end
            total++; if (bus.loading !== m_load) begin bad++; $display("FAIL rnd_loading i=%0d got=%b want=%b", i, bus.loading, m_load); end
            total++; if (bus.ld_ready !== m_load) begin bad++; $display("FAIL rnd_ld_ready i=%0d got=%b want=%b", i, bus.ld_ready, m_load); end
            total++; if (err_oob !== m_oob) begin bad++; $display("FAIL rnd_oob i=%0d got=%b want=%b", i, err_oob, m_oob); end
            total++; if (err_misaligned !== m_mis) begin bad++; $display("FAIL rnd_mis i=%0d got=%b want=%b", i, err_misaligned, m_mis); end
            total++; if (err_addr !== m_eaddr) begin bad++; $display("FAIL rnd_eaddr i=%0d got=%h want=%h", i, err_addr, m_eaddr); end
            total++; if (wr_count !== 16'(m_wr)) begin bad++; $display("FAIL rnd_wr_count i=%0d got=%0d want=%0d", i, wr_count, m_wr); end
            total++; if (ld_count !== 16'(m_ld)) begin bad++; $display("FAIL rnd_ld_count i=%0d got=%0d want=%0d", i, ld_count, m_ld); end
            cycle();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        bus.mem_addr = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_we = 0;
        bus.load_en = 0;
        bus.ld_valid = 0;
        bus.ld_index = '0;
        bus.ld_data = 32'h0;
        #1;
        test_reset();
        test_loader_fill();
        test_core_store();
        test_oob();
        test_misaligned();
        test_mode_isolation();
        test_reset_retention();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
